mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/slc3_mem_pkg.sv | 37 +++
 rtl/sram_wait_cnt.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// -----------------------------------------------------------------------------
// slc3_mem_pkg
// Shared definitions for the SLC-3 asynchronous SRAM access controller:
//   - mem_state_e     : controller FSM states
//   - IO_ADDR         : memory-mapped I/O word address (switches / hex display)
//   - DEF_WAIT_STATES : default read wait states (OE_N low before capture)
//   - DEF_WR_PULSE    : default write strobe width (WE_N low cycles)
//   - CNT_W           : width of the shared wait-state down-counter
//   - cnt_preload()   : converts a cycle count into the counter preload value
// -----------------------------------------------------------------------------
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_SETUP,
    WR_LOW,
    WR_HOLD,
    IO_RD,
    IO_WR
  } mem_state_e;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  localparam int unsigned DEF_WAIT_STATES = 2;
  localparam int unsigned DEF_WR_PULSE    = 2;

  localparam int unsigned CNT_W = 4;

  // The counter is checked for zero on the edge that ends a timed phase, so a
  // phase lasting N cycles is preloaded with N-1.
  function automatic logic [CNT_W-1:0] cnt_preload(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// -----------------------------------------------------------------------------
// sram_wait_cnt
// Loadable 4-bit down-counter with zero flag. Times both the read wait states
// and the write strobe width; the controller loads it when entering a timed
// phase and decrements it while in that phase. It saturates at zero.
//
// Ports:
//   Clk      in   clock, rising edge
//   Reset    in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val on the next edge (has priority over dec)
//   load_val in   preload value
//   dec      in   decrement on the next edge when non-zero
//   zero     out  count is zero
// -----------------------------------------------------------------------------
module sram_wait_cnt
  import slc3_mem_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples values from before the edge, independent of block order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory access controller between the SLC-3 control unit and an asynchronous
// SRAM, with memory-mapped I/O at word address 16'hFFFF.
//
// Accesses (request sampled in IDLE; all strobes registered, active low):
//   SRAM read  : RD_WAIT (WAIT_STATES cycles, CE/OE low) -> RD_DONE (capture
//                already done, Mem_Ready) -> IDLE
//   SRAM write : WR_SETUP (data driven) -> WR_LOW (WR_PULSE cycles, WE low)
//                -> WR_HOLD (WE high, Mem_Ready) -> IDLE
//   I/O read   : IO_RD, one cycle, MDR_In <= Switches, Mem_Ready
//   I/O write  : IO_WR, one cycle, Mem_Ready, HEX_Data <= MDR_out
// A write request wins over a simultaneous read request. A request still high
// after Mem_Ready starts a new access after one IDLE cycle.
//
// Configuration macro: MEM_ACCESS_IO_HEX_EN
//   defined   : writes to 16'hFFFF load the HEX_Data display register
//   undefined : HEX_Data is constant 0 and writes to 16'hFFFF go to SRAM;
//               reads of 16'hFFFF always return Switches
//
// Parameters:
//   WAIT_STATES  read cycles with OE_N low before data capture (1..15)
//   WR_PULSE     cycles WE_N is held low per write (1..15)
//
// Ports:
//   Clk            in   clock, rising edge
//   Reset          in   asynchronous active-high reset
//   Mem_OE         in   read request (level, held until Mem_Ready)
//   Mem_WE         in   write request (level, held until Mem_Ready)
//   MAR            in   word address
//   MDR_out        in   write data
//   Switches       in   I/O read source
//   Mem_Ready      out  one-cycle completion pulse
//   MDR_In         out  registered read data
//   ADDR           out  SRAM address {4'h0, MAR}, latched per access
//   CE_N/OE_N/WE_N out  SRAM strobes
//   UB_N/LB_N      out  byte enables, follow CE_N
//   Data_to_SRAM   out  write data, latched per access
//   Data_OE        out  tri-state drive enable for Data_to_SRAM
//   Data_from_SRAM in   SRAM read data
//   HEX_Data       out  hex display register
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
  parameter int unsigned WR_PULSE    = DEF_WR_PULSE
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_out,
  input  logic [15:0] Switches,
  output logic        Mem_Ready,
  output logic [15:0] MDR_In,
  output logic [19:0] ADDR,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic        UB_N,
  output logic        LB_N,
  output logic [15:0] Data_to_SRAM,
  output logic        Data_OE,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] HEX_Data
);

`ifdef MEM_ACCESS_IO_HEX_EN
  localparam bit IO_WR_EN = 1'b1;
`else
  localparam bit IO_WR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] RD_LOAD = cnt_preload(WAIT_STATES);
  localparam logic [CNT_W-1:0] WR_LOAD = cnt_preload(WR_PULSE);

  mem_state_e       state;
  logic             io_hit;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign io_hit = (MAR == IO_ADDR);

  // Counter control: preload on entry into RD_WAIT (from IDLE) and WR_LOW
  // (from WR_SETUP); count down while inside either timed phase.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = RD_LOAD;
    case (state)
      IDLE: begin
        if (!Mem_WE && Mem_OE && !io_hit) begin
          cnt_load = 1'b1;
          cnt_val  = RD_LOAD;
        end
      end
      WR_SETUP: begin
        cnt_load = 1'b1;
        cnt_val  = WR_LOAD;
      end
      default: ;
    endcase
  end

  assign cnt_dec = (state == RD_WAIT) || (state == WR_LOW);

  sram_wait_cnt u_wait_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Controller FSM. Outputs are registered and set on the edge that enters the
  // state they belong to, so each strobe is glitch-free and aligned with the
  // state it describes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      Mem_Ready    <= 1'b0;
      MDR_In       <= '0;
      ADDR         <= '0;
      Data_to_SRAM <= '0;
      CE_N         <= 1'b1;
      OE_N         <= 1'b1;
      WE_N         <= 1'b1;
      UB_N         <= 1'b1;
      LB_N         <= 1'b1;
      Data_OE      <= 1'b0;
    end else begin
      Mem_Ready <= 1'b0;
      case (state)
        IDLE: begin
          // Address and write data are frozen here for the whole access.
          if (Mem_WE || Mem_OE) begin
            ADDR         <= {4'h0, MAR};
            Data_to_SRAM <= MDR_out;
          end
          if (Mem_WE && io_hit && IO_WR_EN) begin
            state     <= IO_WR;
            Mem_Ready <= 1'b1;
          end else if (Mem_WE) begin
            state   <= WR_SETUP;
            CE_N    <= 1'b0;
            UB_N    <= 1'b0;
            LB_N    <= 1'b0;
            Data_OE <= 1'b1;
          end else if (Mem_OE && io_hit) begin
            state     <= IO_RD;
            MDR_In    <= Switches;
            Mem_Ready <= 1'b1;
          end else if (Mem_OE) begin
            state <= RD_WAIT;
            CE_N  <= 1'b0;
            UB_N  <= 1'b0;
            LB_N  <= 1'b0;
            OE_N  <= 1'b0;
          end
        end

        RD_WAIT: begin
          // Capture on the edge ending the last wait state, so MDR_In is valid
          // in the same cycle Mem_Ready is high.
          if (cnt_zero) begin
            state     <= RD_DONE;
            MDR_In    <= Data_from_SRAM;
            Mem_Ready <= 1'b1;
          end
        end

        RD_DONE: begin
          state <= IDLE;
          CE_N  <= 1'b1;
          UB_N  <= 1'b1;
          LB_N  <= 1'b1;
          OE_N  <= 1'b1;
        end

        WR_SETUP: begin
          state <= WR_LOW;
          WE_N  <= 1'b0;
        end

        WR_LOW: begin
          if (cnt_zero) begin
            state     <= WR_HOLD;
            WE_N      <= 1'b1;
            Mem_Ready <= 1'b1;
          end
        end

        WR_HOLD: begin
          state   <= IDLE;
          CE_N    <= 1'b1;
          UB_N    <= 1'b1;
          LB_N    <= 1'b1;
          Data_OE <= 1'b0;
        end

        IO_RD,
        IO_WR: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_IO_HEX_EN
  // Loaded on the edge entering IO_WR, i.e. visible while Mem_Ready is high.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      HEX_Data <= '0;
    end else if ((state == IDLE) && Mem_WE && io_hit) begin
      HEX_Data <= MDR_out;
    end
  end
`else
  assign HEX_Data = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. A behavioural SRAM answers the
// DUT's strobes; a transaction-level model predicts latency, strobe widths,
// read data and display contents from the access rules.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int unsigned WS = 2;
  localparam int unsigned WP = 2;

`ifdef MEM_ACCESS_IO_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR_out;
  logic [15:0] Switches;
  logic        Mem_Ready;
  logic [15:0] MDR_In;
  logic [19:0] ADDR;
  logic        CE_N;
  logic        OE_N;
  logic        WE_N;
  logic        UB_N;
  logic        LB_N;
  logic [15:0] Data_to_SRAM;
  logic        Data_OE;
  logic [15:0] Data_from_SRAM = 16'h0000;
  logic [15:0] HEX_Data;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_ctrl #(
    .WAIT_STATES (WS),
    .WR_PULSE    (WP)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Mem_OE         (Mem_OE),
    .Mem_WE         (Mem_WE),
    .MAR            (MAR),
    .MDR_out        (MDR_out),
    .Switches       (Switches),
    .Mem_Ready      (Mem_Ready),
    .MDR_In         (MDR_In),
    .ADDR           (ADDR),
    .CE_N           (CE_N),
    .OE_N           (OE_N),
    .WE_N           (WE_N),
    .UB_N           (UB_N),
    .LB_N           (LB_N),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_OE        (Data_OE),
    .Data_from_SRAM (Data_from_SRAM),
    .HEX_Data       (HEX_Data)
  );

  always #5 Clk = ~Clk;

  // Behavioural SRAM: sampled mid-cycle while the DUT's registered strobes
  // are stable. Unwritten locations read as zero.
  logic [15:0] sram [logic [19:0]];

  always @(negedge Clk) begin
    if (!CE_N && !WE_N) sram[ADDR] = Data_to_SRAM;
    if (!CE_N && !OE_N) Data_from_SRAM = sram.exists(ADDR) ? sram[ADDR] : 16'h0000;
    else                Data_from_SRAM = 16'hDEAD;
  end

  // Reference model state.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_mdr;
  logic [15:0] exp_hex;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_invariants();
    check("oe_we_never_both_low", 32'(OE_N | WE_N), 32'd1);
    check("no_drive_while_oe", 32'(Data_OE & ~OE_N), 32'd0);
    check("ub_lb_follow_ce", 32'({UB_N, LB_N}), 32'({CE_N, CE_N}));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(Mem_Ready), 32'd0);
    check({tag, "_strobes"}, 32'({CE_N, OE_N, WE_N, Data_OE}), 32'b1110);
  endtask

  // Expected latency (cycles from the sampling edge to the Mem_Ready cycle)
  // and strobe widths, from the access rules.
  task automatic predict(input logic we, input logic oe, input logic [15:0] mar,
                         output int lat, output int e_oe, output int e_we,
                         output int e_doe, output int e_ce,
                         output bit io_rd, output bit io_wr, output bit sram_rd);
    bit sram_wr;
    io_rd   = !we && oe && (mar == 16'hFFFF);
    io_wr   = we && (mar == 16'hFFFF) && HEX_EN;
    sram_rd = !we && oe && !io_rd;
    sram_wr = we && !io_wr;
    lat   = (io_rd || io_wr) ? 1 : (sram_rd ? int'(WS) + 1 : int'(WP) + 2);
    e_oe  = sram_rd ? int'(WS) + 1 : 0;
    e_we  = sram_wr ? int'(WP) : 0;
    e_doe = sram_wr ? int'(WP) + 2 : 0;
    e_ce  = sram_rd ? int'(WS) + 1 : (sram_wr ? int'(WP) + 2 : 0);
  endtask

  // One access; called right after a falling edge. MAR/MDR_out are scrambled
  // after the sampling edge to confirm they were latched.
  task automatic do_access(input logic we, input logic oe, input logic [15:0] mar,
                           input logic [15:0] wdata, input logic [15:0] sw,
                           input bit drop_early);
    int lat, e_oe, e_we, e_doe, e_ce;
    int n, c_oe, c_we, c_doe, c_ce;
    bit io_rd, io_wr, sram_rd, got_ready;
    predict(we, oe, mar, lat, e_oe, e_we, e_doe, e_ce, io_rd, io_wr, sram_rd);
    if (io_rd)   exp_mdr = sw;
    if (sram_rd) exp_mdr = mem_rd(mar);
    if (io_wr)   exp_hex = wdata;

    Mem_WE = we; Mem_OE = oe; MAR = mar; MDR_out = wdata; Switches = sw;
    @(posedge Clk);
    n = 0; c_oe = 0; c_we = 0; c_doe = 0; c_ce = 0; got_ready = 1'b0;
    while (!got_ready && n < 40) begin
      @(negedge Clk);
      n++;
      check_invariants();
      if (!OE_N)   c_oe++;
      if (!WE_N)   c_we++;
      if (Data_OE) c_doe++;
      if (!CE_N) begin
        c_ce++;
        check("addr_stable", 32'(ADDR), 32'({4'h0, mar}));
      end
      if (Data_OE) check("wdata_stable", 32'(Data_to_SRAM), 32'(wdata));
      if (Mem_Ready) got_ready = 1'b1;
      if (n == 1) begin
        MAR = 16'($urandom);
        MDR_out = 16'($urandom);
        if (drop_early) begin Mem_WE = 1'b0; Mem_OE = 1'b0; end
      end
    end
    Mem_WE = 1'b0; Mem_OE = 1'b0;
    check("latency", 32'(n), 32'(lat));
    check("oe_low_cycles", 32'(c_oe), 32'(e_oe));
    check("we_low_cycles", 32'(c_we), 32'(e_we));
    check("data_oe_cycles", 32'(c_doe), 32'(e_doe));
    check("ce_low_cycles", 32'(c_ce), 32'(e_ce));
    check("mdr_in", 32'(MDR_In), 32'(exp_mdr));
    check("hex_data", 32'(HEX_Data), 32'(exp_hex));
    if (we && !io_wr) ref_mem[mar] = wdata;
    @(negedge Clk);
    check_idle("after_access");
  endtask

  // Request held high across two complete accesses.
  task automatic do_b2b(input logic we, input logic [15:0] mar, input logic [15:0] wdata);
    int lat, e_oe, e_we, e_doe, e_ce;
    int n, pulses, p1, p2;
    bit io_rd, io_wr, sram_rd;
    predict(we, !we, mar, lat, e_oe, e_we, e_doe, e_ce, io_rd, io_wr, sram_rd);
    if (sram_rd) exp_mdr = mem_rd(mar);
    Mem_WE = we; Mem_OE = !we; MAR = mar; MDR_out = wdata;
    @(posedge Clk);
    n = 0; pulses = 0; p1 = 0; p2 = 0;
    while (pulses < 2 && n < 60) begin
      @(negedge Clk);
      n++;
      check_invariants();
      if (Mem_Ready) begin
        pulses++;
        if (pulses == 1) p1 = n;
        else begin
          p2 = n;
          Mem_WE = 1'b0; Mem_OE = 1'b0;
        end
        if (!we) check("b2b_rdata", 32'(MDR_In), 32'(exp_mdr));
      end
    end
    Mem_WE = 1'b0; Mem_OE = 1'b0;
    check("b2b_first_ready", 32'(p1), 32'(lat));
    check("b2b_second_ready", 32'(p2), 32'(2 * lat + 1));
    if (we) ref_mem[mar] = wdata;
    @(negedge Clk);
    check_idle("after_b2b");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, 32'({CE_N, OE_N, WE_N, UB_N, LB_N, Data_OE, Mem_Ready}), 32'b1111100);
    check({tag, "_mdr_in"}, 32'(MDR_In), 32'(exp_mdr));
    check({tag, "_hex"}, 32'(HEX_Data), 32'(exp_hex));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we, oe;
    logic [15:0] mar;
    int          k;

    exp_mdr = 16'h0000;
    exp_hex = 16'h0000;
    Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0;
    MAR = '0; MDR_out = '0; Switches = '0;
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset_state");
    Reset = 1'b0;

    // First request is taken on the first rising edge after reset.
    do_access(1'b1, 1'b0, 16'h0003, 16'hBEEF, 16'h0000, 1'b0);
    do_access(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h0000, 1'b0);
    do_access(1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000, 1'b0);
    do_access(1'b1, 1'b1, 16'h0020, 16'h5A5A, 16'h0000, 1'b0);
    do_access(1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b0);
    do_access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h00A5, 1'b0);
    do_access(1'b1, 1'b0, 16'hFFFF, 16'h0042, 16'h0000, 1'b0);
    do_access(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b1);
    do_access(1'b1, 1'b0, 16'h0004, 16'hC0DE, 16'h0000, 1'b1);
    do_access(1'b0, 1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b0);

    do_b2b(1'b0, 16'h0003, 16'h0000);
    do_b2b(1'b1, 16'h0005, 16'h7777);

    // Reset in the middle of the write strobe.
    Mem_WE = 1'b1; Mem_OE = 1'b0; MAR = 16'h0050; MDR_out = 16'h9999;
    @(posedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    check("pre_reset_we_low", 32'(WE_N), 32'd0);
    #1 Reset = 1'b1;
    Mem_WE = 1'b0;
    exp_mdr = 16'h0000;
    exp_hex = 16'h0000;
    #1 check_reset_outputs("mid_write_reset");
    #1 Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check_idle("post_reset_quiet");
    end

    for (int i = 0; i < 60; i++) begin
      k  = int'($urandom_range(0, 7));
      we = (k >= 3);
      oe = (k < 3) || (k >= 6);
      mar = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
      do_access(we, oe, mar, 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
